uart_tx_param: RTL
==================

Name: uart_tx_param

Overview:
Parametrised successor UART transmitter. It serialises one frame per accepted word: start bit, DATA_BITS data bits LSB-first, an optional parity bit, then 1 or 2 stop bits. Bit period is tick_div clock cycles, latched per frame. It uses a valid/ready handshake, so a host or FIFO can stream frames back-to-back with no idle gap. It replaces the fixed 8N1 transmitter in the UART path.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame; legal 1 or 2
DIV_W, 4, width of the tick_div bit-period input

Ports:
tick  input  1  sole clock, rising edge
rst  input  1  asynchronous, active-high reset
tx_valid  input  1  host has a word on tx_data
tx_data  input  DATA_BITS  word to send
tx_ready  output  1  block accepts tx_data this cycle when tx_valid=1
tick_div  input  DIV_W  clock cycles per bit; 0 is treated as 1
tx_serial  output  1  serial line, idle high
tx_active  output  1  high from the start-bit cycle through the last stop-bit cycle
tx_done  output  1  one-cycle pulse on the last cycle of the last stop bit

Behaviour:
- Reset (asynchronous, rst=1):
  - tx_serial=1, tx_active=0, tx_done=0, tx_ready=0 while rst=1.
  - State goes to IDLE and all counters clear.
  - Reset mid-frame aborts the frame immediately: the line returns high and the word is discarded.
- Handshake:
  - Accept occurs on a rising edge where tx_valid & tx_ready.
  - tx_data and tick_div are latched on accept. Changes after accept do not affect the frame in flight.
- tx_ready is high:
  - in IDLE (after reset is released), and
  - in the last cycle of the last stop bit (back-to-back accept).
  - It is low otherwise.
- Latency: the first start-bit cycle on tx_serial is the cycle after the accepting edge.
- States and transitions:
  - IDLE: tx_serial=1. On accept, go to START.
  - START: tx_serial=0 for div cycles. Then go to DATA with bit index 0.
  - DATA: tx_serial=shift[0] for div cycles, then shift right. After DATA_BITS bits, go to PARITY if PARITY!=0, else STOP.
  - PARITY: tx_serial = XOR of the latched data (even), or its inverse (odd), for div cycles. Then go to STOP.
  - STOP: tx_serial=1 for STOP_BITS*div cycles. On the final cycle, pulse tx_done. Then go to START if an accept occurred on that edge, else IDLE.
- Bit timer:
  - Counter of width DIV_W, 0..div-1, where div = max(tick_div_latched, 1).
  - Bit boundary when count == div-1. The counter clears at every state change.
  - Bit index counter has width clog2(DATA_BITS+1). Stop-bit counter is 1 bit.
- Frame length in cycles: div*(1 + DATA_BITS + (PARITY!=0) + STOP_BITS).
- tx_active: set on entry to START, cleared on leaving STOP to IDLE. It stays high across back-to-back frames.
- Simultaneous events:
  - A back-to-back accept and tx_done occur on the same edge: tx_done pulses and the next frame starts without any idle cycle.
  - tx_valid high in a non-ready cycle is ignored. The host must hold it until accepted.
- No combinational path from tx_valid to tx_ready. tx_ready depends only on state and counters.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding: IDLE, START, DATA, PARITY, STOP;
  - parity mode constants: PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - a function computing frame length in bits.
- One natural sub-module, uart_bit_timer. Inputs: tick, rst, clear, div. Output: bit_end.
- The FSM, shift register and parity logic stay in uart_tx_param.

Test Plan:
- Reset behaviour: assert rst mid-START of the frame for 0x55 -> tx_serial=1, tx_active=0 and tx_done=0 in the same cycle. tx_ready=1 one cycle after rst deasserts.
- 8N1, div=4, send 0xA5 -> line reads 0, then 1,0,1,0,0,1,0,1, then 1. Each bit lasts 4 cycles (40 cycles total). tx_done pulses once, at cycle 40.
- DATA_BITS=7, PARITY=1, STOP_BITS=2, div=2, send 0x13 -> parity bit is 1. Frame is 22 cycles, and both stop bits are high.
- PARITY=2, send 0x00 -> parity bit is 1. Send 0x01 -> parity bit is 0.
- Back-to-back: tx_valid held high with 0x0F then 0xF0, div=3 -> second start bit directly follows the last stop cycle. tx_active stays high throughout, and tx_done pulses twice 30 cycles apart.
- tick_div=0 -> each bit lasts 1 cycle. tick_div changed mid-frame -> the current frame keeps its latched div.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: state encoding,
// parity mode constants and a frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Bits on the line for one frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..div-1 and flags the last cycle of each bit.
// A div of zero behaves as one, so every cycle is a bit boundary.
module uart_bit_timer #(
    parameter int DIV_W = 4
) (
    input  logic             tick,
    input  logic             rst,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             bit_end
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] last;

    always_comb begin
        last    = (div == '0) ? '0 : div - DIV_W'(1);
        bit_end = (count == last);
    end

    always_ff @(posedge tick or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || bit_end) begin
            count <= '0;
        end else begin
            count <= count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input: start bit, LSB-first
// data, optional parity, 1 or 2 stop bits, back-to-back frames without gaps.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 4
) (
    input  logic                 tick,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    input  logic [DIV_W-1:0]     tick_div,
    output logic                 tx_serial,
    output logic                 tx_active,
    output logic                 tx_done
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);

    // Handshake: a word is accepted on a rising edge where tx_valid & tx_ready.
    // tx_ready is a function of state and counters only, never of tx_valid.
    tx_state_t            state;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic [DIV_W-1:0]     div_lat;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic                 armed;
    logic                 bit_end;
    logic                 timer_clear;
    logic                 last_stop;
    logic                 accept;

    assign timer_clear = (state == ST_IDLE);

    uart_bit_timer #(.DIV_W(DIV_W)) u_bit_timer (
        .tick    (tick),
        .rst     (rst),
        .clear   (timer_clear),
        .div     (div_lat),
        .bit_end (bit_end)
    );

    always_comb begin
        last_stop = (state == ST_STOP) && bit_end && (stop_idx == 1'(STOP_BITS - 1));
        tx_ready  = ((state == ST_IDLE) && armed) || last_stop;
        accept    = tx_valid && tx_ready;
        tx_done   = last_stop;
        tx_active = (state != ST_IDLE);
        tx_serial = 1'b1;
        unique case (state)
            ST_IDLE:   tx_serial = 1'b1;
            ST_START:  tx_serial = 1'b0;
            ST_DATA:   tx_serial = shift[0];
            ST_PARITY: tx_serial = par_bit;
            ST_STOP:   tx_serial = 1'b1;
            default:   tx_serial = 1'b1;
        endcase
    end

    always_ff @(posedge tick or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            shift    <= '0;
            par_bit  <= 1'b0;
            div_lat  <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            armed    <= 1'b0;
        end else begin
            // armed keeps tx_ready low for the first cycle after reset release.
            armed <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shift   <= tx_data;
                        par_bit <= (^tx_data) ^ (PARITY == PAR_ODD);
                        div_lat <= tick_div;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift <= shift >> 1;
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            stop_idx <= 1'b0;
                            state    <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        stop_idx <= 1'b0;
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (last_stop) begin
                        // A word offered in the final stop cycle starts the next frame directly.
                        if (accept) begin
                            shift   <= tx_data;
                            par_bit <= (^tx_data) ^ (PARITY == PAR_ODD);
                            div_lat <= tick_div;
                            state   <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (bit_end) begin
                        stop_idx <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
